// File: rtl/instruction_fetch_unit.sv
// Instruction fetch front end for the MIPS datapath.
// The unit owns the PC and requests instruction words through a valid handshake.
// It holds each fetched word until the datapath accepts it.
// On each accept it computes the next PC (jump > taken branch > sequential)
// and counts the retired instruction.
module instruction_fetch_unit #(
    parameter logic [31:0] PC_RESET     = 32'h0040_0000,
    parameter int unsigned MEMORY_DEPTH = 64,
    localparam int unsigned ADDR_W      = $clog2(MEMORY_DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_reset,
    output logic              o_imem_req,
    output logic [ADDR_W-1:0] o_imem_addr,
    input  logic              i_imem_valid,
    input  logic [31:0]       i_imem_data,
    output logic [31:0]       o_instruction,
    output logic              o_instr_valid,
    input  logic              i_advance,
    input  logic              i_branch_eq,
    input  logic              i_branch_ne,
    input  logic              i_zero,
    input  logic [31:0]       i_branch_offset,
    input  logic              i_jump,
    input  logic [25:0]       i_jump_target,
    output logic [31:0]       o_pc,
    output logic [31:0]       o_pc_plus4,
    output logic [31:0]       o_retired_count
);

    typedef enum logic [1:0] {
        StFetch  = 2'd0,
        StWait   = 2'd1,
        StIssued = 2'd2
    } state_e;

    state_e      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instruction;
    logic        r_instr_valid;
    logic [31:0] r_retired_count;

    logic [31:0] w_pc_plus4;
    logic        w_branch_taken;
    logic [31:0] w_next_pc;

    assign w_pc_plus4     = r_pc + 32'd4;
    assign w_branch_taken = (i_branch_eq & i_zero) | (i_branch_ne & ~i_zero);

    // Next-PC selection: jump wins over a taken branch, which wins over sequential flow.
    always_comb begin
        w_next_pc = w_pc_plus4;
        if (i_jump) begin
            w_next_pc = {w_pc_plus4[31:28], i_jump_target, 2'b00};
        end else if (w_branch_taken) begin
            // The shift drops the offset's two MSBs; the sum wraps at 32 bits.
            w_next_pc = w_pc_plus4 + (i_branch_offset << 2);
        end
    end

    // Fetch FSM together with the PC, the held instruction and the retire counter.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state         <= StFetch;
            r_pc            <= PC_RESET;
            r_instruction   <= 32'd0;
            r_instr_valid   <= 1'b0;
            r_retired_count <= 32'd0;
        end else begin
            case (r_state)
                StFetch: begin
                    r_state <= StWait;
                end
                StWait: begin
                    if (i_imem_valid) begin
                        r_instruction <= i_imem_data;
                        r_instr_valid <= 1'b1;
                        r_state       <= StIssued;
                    end
                end
                StIssued: begin
                    if (i_advance) begin
                        r_retired_count <= r_retired_count + 32'd1;
                        r_instr_valid   <= 1'b0;
                        r_pc            <= w_next_pc & ~32'h3;
                        r_state         <= StFetch;
                    end
                end
                default: begin
                    r_state <= StFetch;
                end
            endcase
        end
    end

    // The request is decoded from the state register.
    // It is gated off while reset is held.
    assign o_imem_req      = ~i_reset & ((r_state == StFetch) | (r_state == StWait));
    assign o_imem_addr     = ADDR_W'((r_pc - PC_RESET) >> 2);
    assign o_instruction   = r_instruction;
    assign o_instr_valid   = r_instr_valid;
    assign o_pc            = r_pc;
    assign o_pc_plus4      = w_pc_plus4;
    assign o_retired_count = r_retired_count;

endmodule
